// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_ONE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        MEAS_HIGH = 3'd2,
        MEAS_LOW  = 3'd3,
        STUCK_ST  = 3'd4
    } state_t;

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_lvl_s;
    logic                   lvl_s;
    logic                   lvl_d_r;
    logic                   rise_s;
    logic                   fall_s;
    logic                   timeout_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       hcnt_r;
    state_t                 state_r;

    // Metastability synchronizer for the asynchronous PWM input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_lvl_s = sync_r[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);

    logic [FW-1:0] filt_cnt_r;
    logic          filt_lvl_r;

    // Accept a new level only after it has been stable for FILT_LEN cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_r <= '0;
            filt_lvl_r <= 1'b0;
        end else if (sync_lvl_s == filt_lvl_r) begin
            filt_cnt_r <= '0;
        end else if (filt_cnt_r == FW'(FILT_LEN - 1)) begin
            filt_cnt_r <= '0;
            filt_lvl_r <= sync_lvl_s;
        end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
        end
    end

    assign lvl_s = filt_lvl_r;
`else
    assign lvl_s = sync_lvl_s;
`endif

    // Delayed level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_d_r <= 1'b0;
        end else begin
            lvl_d_r <= lvl_s;
        end
    end

    assign rise_s = lvl_s & ~lvl_d_r;
    assign fall_s = ~lvl_s & lvl_d_r;

    // Timeout fires on the cycle cnt would reach saturation; any edge that cycle wins
    assign timeout_s = (cnt_r == CNT_PRE) & ~rise_s & ~fall_s;

    // Cycle counter restarted by each rise, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (rise_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // High-time capture at the falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_r <= '0;
        end else if (fall_s) begin
            hcnt_r <= cnt_r;
        end else begin
            hcnt_r <= hcnt_r;
        end
    end

    // Measurement FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (timeout_s) begin
                        state_r     <= STUCK_ST;
                        stuck       <= 1'b1;
                        stuck_level <= lvl_s;
                    end else if (!lvl_s) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARMED: begin
                    if (rise_s) begin
                        state_r <= MEAS_HIGH;
                    end else if (timeout_s) begin
                        state_r     <= STUCK_ST;
                        stuck       <= 1'b1;
                        stuck_level <= lvl_s;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                MEAS_HIGH: begin
                    if (fall_s) begin
                        state_r <= MEAS_LOW;
                    end else if (timeout_s) begin
                        state_r     <= STUCK_ST;
                        stuck       <= 1'b1;
                        stuck_level <= lvl_s;
                    end else begin
                        state_r <= MEAS_HIGH;
                    end
                end
                MEAS_LOW: begin
                    if (rise_s) begin
                        state_r    <= MEAS_HIGH;
                        period     <= cnt_r;
                        high_time  <= hcnt_r;
                        meas_valid <= 1'b1;
                    end else if (timeout_s) begin
                        state_r     <= STUCK_ST;
                        stuck       <= 1'b1;
                        stuck_level <= lvl_s;
                    end else begin
                        state_r <= MEAS_LOW;
                    end
                end
                STUCK_ST: begin
                    // A rise restarts measurement but the interval before it is not reported
                    if (rise_s) begin
                        state_r     <= MEAS_HIGH;
                        stuck       <= 1'b0;
                        stuck_level <= 1'b0;
                    end else if (fall_s) begin
                        state_r     <= ARMED;
                        stuck       <= 1'b0;
                        stuck_level <= 1'b0;
                    end else begin
                        state_r <= STUCK_ST;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    stuck       <= 1'b0;
                    stuck_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture with a scoreboard queue of expected measurements.
module tb_pwm_capture;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int H2      = 5;
    localparam int L2      = 5;
    localparam int LAT_ADD = FILT;
`else
    localparam int H2      = 3;
    localparam int L2      = 5;
    localparam int LAT_ADD = 0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    int   errors = 0;
    int   checks = 0;
    int   strobes = 0;
    int   cyc_n = 0;
    int   rise_cyc = 0;
    int   first_strobe_cyc = 0;
    bit   seen_stuck = 1'b0;
    exp_t sb_q[$];

    pwm_capture #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_drained(input string tag);
        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL %s observed=%0d pending expected=0 pending", tag, sb_q.size());
        end
    endtask

    task automatic mon();
        exp_t e;
        if (stuck === 1'b1) seen_stuck = 1'b1;
        if (meas_valid === 1'b1) begin
            if (strobes == 0) first_strobe_cyc = cyc_n;
            strobes++;
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL strobe_unexpected observed=1 expected=0 cycle=%0d", cyc_n);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val("period", period, e.p);
                check_val("high_time", high_time, e.h);
            end
        end
    endtask

    task automatic cyc(input logic v);
        pwm_in = v;
        @(negedge clk);
        cyc_n++;
        mon();
    endtask

    task automatic push(input int p, input int h);
        exp_t e;
        e.p = CNT_W'(p);
        e.h = CNT_W'(h);
        sb_q.push_back(e);
    endtask

    task automatic pwm(input int h, input int l, input bit exp_en, input int ep, input int eh);
        if (exp_en) push(ep, eh);
        repeat (h) cyc(1'b1);
        repeat (l) cyc(1'b0);
    endtask

    initial begin
        int lat;
        rst    = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        cyc(1'b0);
        cyc(1'b0);
        check_val("rst_period", period, 8'd0);
        check_val("rst_high_time", high_time, 8'd0);
        check_bit("rst_meas_valid", meas_valid, 1'b0);
        check_bit("rst_stuck", stuck, 1'b0);
        check_bit("rst_stuck_level", stuck_level, 1'b0);
        rst = 1'b0;

        // 5 periods of 10/30: four strobes, first only after the second rise
        repeat (4) cyc(1'b0);
        rise_cyc = cyc_n;
        for (int k = 0; k < 5; k++) pwm(10, 30, k > 0, 40, 10);
        check_drained("t1_drained");
        lat = first_strobe_cyc - rise_cyc;
        checks++;
        assert (lat >= 40 + SYNC && lat <= 40 + SYNC + 3 + LAT_ADD) else begin
            errors++;
            $error("FAIL t1_first_strobe_latency observed=%0d expected=%0d..%0d", lat, 40 + SYNC, 40 + SYNC + 3 + LAT_ADD);
        end

        // Reset in the 15th cycle of a period clears outputs and discards the period
        pwm(10, 4, 1'b1, 40, 10);
        check_val("t5_pre_rst_period", period, 8'd40);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        check_val("t5_rst_period", period, 8'd0);
        check_val("t5_rst_high_time", high_time, 8'd0);
        check_bit("t5_rst_meas_valid", meas_valid, 1'b0);
        repeat (25) cyc(1'b0);
        pwm(10, 30, 1'b0, 0, 0);
        pwm(10, 30, 1'b1, 40, 10);
        check_drained("t5_drained");

`ifdef PWM_CAPTURE_FILTER_EN
        // 20/20 PWM with 2-cycle glitches mid-high and mid-low
        for (int k = 0; k < 4; k++) begin
            if (k == 0) push(40, 10);
            else push(40, 20);
            repeat (8) cyc(1'b1);
            repeat (2) cyc(1'b0);
            repeat (10) cyc(1'b1);
            repeat (8) cyc(1'b0);
            repeat (2) cyc(1'b1);
            repeat (10) cyc(1'b0);
        end
        check_drained("t4_drained");
`else
        // 1-cycle high / 1-cycle low at the minimum measurable widths
        for (int k = 0; k < 10; k++) begin
            if (k == 0) pwm(1, 1, 1'b1, 40, 10);
            else pwm(1, 1, 1'b1, 2, 1);
        end
        repeat (6) cyc(1'b0);
        check_drained("t3_drained");
`endif

        // Input held high through reset: no strobe, then stuck high
        rst = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        rst = 1'b0;
        repeat (240) cyc(1'b1);
        check_bit("t2_stuck_early", stuck, 1'b0);
        repeat (35) cyc(1'b1);
        check_bit("t2_stuck", stuck, 1'b1);
        check_bit("t2_stuck_level", stuck_level, 1'b1);
        repeat (10) cyc(1'b0);
        check_bit("t2_stuck_cleared", stuck, 1'b0);
        pwm(H2, L2, 1'b0, 0, 0);
        pwm(H2, L2, 1'b1, H2 + L2, H2);
        repeat (8) cyc(1'b0);
        check_drained("t2_drained");
        check_bit("t2_stuck_after", stuck, 1'b0);

        // Rise on the cycle cnt would saturate: measured normally, no stuck
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        repeat (3) cyc(1'b0);
        seen_stuck = 1'b0;
        pwm(10, 244, 1'b0, 0, 0);
        pwm(10, 244, 1'b1, 254, 10);
        pwm(5, 5, 1'b1, 254, 10);
        repeat (6) cyc(1'b0);
        check_drained("t6_drained");
        check_bit("t6_never_stuck", seen_stuck, 1'b0);
        repeat (260) cyc(1'b0);
        check_bit("t6_stuck_low", stuck, 1'b1);
        check_bit("t6_stuck_level_low", stuck_level, 1'b0);
        check_val("t6_period_kept", period, 8'd254);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
